atom_bank_mapper: RTL and testbench
===================================

# atom_bank_mapper

Clocked, parametrised successor to the Atom RAM/ROM-box decoder: maps NUM_WIN independent 4 KB CPU windows onto any of 2^BANK_BITS 4 KB banks of the external RAM or ROM, each window individually selectable as RAM or ROM and individually write-protectable. It sits beside the fixed Atom decoder on the CPU bus, runs from a fast system clock that oversamples PHI2, and generates delayed, glitch-free strobes. A key-protected lock prevents runaway code from remapping.

## Interface
Parameters:
- NUM_WIN, 4: number of windows (1-8).
- WIN_PAGES, 32'h0000EA76: 4 bits per window, Addr[15:12] page of window i = WIN_PAGES[4i+3:4i]; default maps windows 0-3 to $6xxx, $7xxx, $Axxx, $Exxx.
- BANK_BITS, 5: bank-number width (1-6).
- REG_BASE, 16'hBFE0: address of bank register 0.
- STROBE_DLY, 2: Clk cycles from synchronised PHI2 rise to strobe assertion (1-7).

Ports:
- Clk  in  1  system clock; at least 8x PHI2.
- Reset  in  1  synchronous, active-high.
- PHI2  in  1  6502 PHI2, asynchronous to Clk.
- Addr  in  16  CPU address.
- RW  in  1  CPU read/write, 1 = read.
- DataIn  in  8  CPU data bus, input side.
- DataOut  out  8  register read data.
- DataOE  out  1  drive DataOut onto CPU bus.
- RA  out  BANK_BITS  memory bank address lines (A12 upward).
- NRAMCS  out  1  RAM chip select, active low.
- NROMCS  out  1  ROM chip select, active low.
- NRDS  out  1  read strobe, active low.
- NWDS  out  1  write strobe, active low.
- Locked  out  1  lock state.

## Operation
- Registers: Bank[i] at REG_BASE+i: bit7 IsRAM, bit6 WP, bits[BANK_BITS-1:0] bank, other bits read 0. Ctrl at REG_BASE+NUM_WIN: bits[NUM_WIN-1:0] window enables, bit7 lock (reads Locked). Key at REG_BASE+NUM_WIN+1: write-only, reads 0.
- Reset values: all Bank = 0, enables = 0, Locked = 0, key FSM K_IDLE, strobe FSM S_IDLE; NRDS = NWDS = 1, DataOE = 0, DataOut = 0.
- Window hit i: Addr[15:12] == page i and enable i; lowest index wins on duplicate pages. Hit: RA = Bank[i] bank field; NRAMCS low if IsRAM, else NROMCS low; writes to a WP RAM window keep NRAMCS high; ROM windows never assert NRAMCS. No hit: both CS high, RA = 0. Decode is combinational from Addr and registers.
- Register read: DataOE = PHI2 & RW & Addr in register range (raw PHI2, combinational); DataOut = addressed register.
- Register write: Addr/RW/DataIn sampled every Clk while synchronised PHI2 is high; committed on the Clk detecting synchronised fall, using the last high-phase sample.
- Lock: writing Ctrl with bit7 = 1 sets Locked (enables written in the same write). While Locked, Bank/Ctrl writes are ignored. Unlock: write $A5 then $5A to Key as consecutive writes to the block; clears Locked.
- Key FSM: K_IDLE -> K_A5 on Key write $A5. K_A5 -> K_IDLE on any block write; if that write is Key $5A, Locked <= 0. $A5 in K_A5 stays K_A5. Non-block cycles do not disturb state.

## Timing
- PHI2 through 2-flop synchroniser; edges from a third delayed flop.
- Strobe FSM: S_IDLE -> S_DLY on sync rise (counter = STROBE_DLY-1); S_DLY counts down, -> S_ACT at 0; S_ACT asserts NRDS (RW=1) or NWDS (RW=0, RW sampled on entry); -> S_IDLE on sync fall, strobe released on that same Clk. Fall during S_DLY -> S_IDLE, no strobe.
- Strobes registered, glitch-free; ≥1 Clk deasserted between cycles.
- Register commit and strobe release occur on the same Clk; new values visible to decode on the next Clk.
- Reset mid-cycle: strobes deassert on the reset Clk, pending commit dropped; normal operation resumes on the next sync rise after Reset falls.

## Test plan
- Reset, read $BFE0-$BFE5 -> all 0; access $A123 -> NRAMCS = NROMCS = 1, RA = 0.
- Write Bank2 = $85, Ctrl = $04; read $A000 -> NRAMCS = 0, RA = 5'h05; NRDS low STROBE_DLY+3 Clk after PHI2 rise, high 3 Clk after PHI2 fall.
- Bank2 = $C3 (RAM, WP): write $A010 -> NRAMCS = 1, NWDS pulses; read $A010 -> NRAMCS = 0.
- Ctrl = $84 -> Locked = 1; write Bank2 = $01 -> readback $C3; Key $A5, $5A -> Locked = 0; Key $A5, Bank0 write, Key $5A -> Locked stays 1.
- WIN_PAGES window0 = window1 = $6, both enabled -> $6xxx uses Bank0.
- Reset asserted with NWDS low -> NWDS = 1 next Clk, no register change.

Source files
------------

// File: rtl/atom_bank_mapper.sv
// atom_bank_mapper
// Maps NUM_WIN independent 4 KB CPU windows onto 4 KB banks of external
// RAM or ROM. Each window has its own bank number, RAM/ROM select and write
// protect. A control register enables windows and can lock the map. The
// lock is cleared only by writing $A5 and then $5A to the key register.
// Memory strobes are timed from a synchronised copy of PHI2.
//
// Ports:
//   Clk      system clock, at least 8x PHI2
//   Reset    synchronous, active-high
//   PHI2     6502 PHI2, asynchronous to Clk
//   Addr     CPU address
//   RW       CPU read/write, 1 = read
//   DataIn   CPU data bus, input side
//   DataOut  register read data
//   DataOE   drive DataOut onto the CPU bus
//   RA       bank address lines (A12 upward)
//   NRAMCS   RAM chip select, active low
//   NROMCS   ROM chip select, active low
//   NRDS     read strobe, active low, registered
//   NWDS     write strobe, active low, registered
//   Locked   lock state
module atom_bank_mapper #(
  parameter int          NUM_WIN    = 4,
  parameter logic [31:0] WIN_PAGES  = 32'h0000EA76,
  parameter int          BANK_BITS  = 5,
  parameter logic [15:0] REG_BASE   = 16'hBFE0,
  parameter int          STROBE_DLY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PHI2,
  input  logic [15:0]          Addr,
  input  logic                 RW,
  input  logic [7:0]           DataIn,
  output logic [7:0]           DataOut,
  output logic                 DataOE,
  output logic [BANK_BITS-1:0] RA,
  output logic                 NRAMCS,
  output logic                 NROMCS,
  output logic                 NRDS,
  output logic                 NWDS,
  output logic                 Locked
);

  localparam logic [15:0] CTRL_OFF = 16'(NUM_WIN);
  localparam logic [15:0] KEY_OFF  = 16'(NUM_WIN + 1);
  localparam logic [2:0]  DLY_LOAD = 3'(STROBE_DLY - 1);

  typedef enum logic [1:0] {S_IDLE, S_DLY, S_ACT} strobe_state_t;
  typedef enum logic       {K_IDLE, K_A5}         key_state_t;

  // PHI2 synchroniser. Not reset, so a Reset released while PHI2 is high
  // does not manufacture a rising edge part-way through a bus cycle.
  logic phi_s1_reg, phi_s2_reg, phi_s3_reg;
  logic phi_rise, phi_fall;

  always_ff @(posedge Clk) begin
    phi_s1_reg <= PHI2;
    phi_s2_reg <= phi_s1_reg;
    phi_s3_reg <= phi_s2_reg;
  end

  assign phi_rise = phi_s2_reg & ~phi_s3_reg;
  assign phi_fall = ~phi_s2_reg & phi_s3_reg;

  // Bus sample, refreshed every Clk of the high phase; on the falling-edge
  // Clk it still holds the last high-phase value.
  logic [15:0] addr_smp_reg;
  logic        rw_smp_reg;
  logic [7:0]  data_smp_reg;

  always_ff @(posedge Clk) begin
    if (phi_s2_reg) begin
      addr_smp_reg <= Addr;
      rw_smp_reg   <= RW;
      data_smp_reg <= DataIn;
    end
  end

  // A cycle is only committed if its rising edge was seen since Reset.
  logic cycle_valid_reg;

  always_ff @(posedge Clk) begin
    if (Reset)         cycle_valid_reg <= 1'b0;
    else if (phi_rise) cycle_valid_reg <= 1'b1;
    else if (phi_fall) cycle_valid_reg <= 1'b0;
  end

  // Register write commit
  logic [15:0] smp_off;
  logic        commit_wr, bank_we, ctrl_we, key_we, unlock;
  logic        locked_reg;

  assign smp_off   = addr_smp_reg - REG_BASE;
  assign commit_wr = phi_fall & cycle_valid_reg & ~rw_smp_reg & (smp_off <= KEY_OFF);
  assign bank_we   = commit_wr & ~locked_reg & (smp_off < CTRL_OFF);
  assign ctrl_we   = commit_wr & ~locked_reg & (smp_off == CTRL_OFF);
  assign key_we    = commit_wr & (smp_off == KEY_OFF);

  // Per-window bank registers and hit detection
  logic                 win_isram_reg [NUM_WIN];
  logic                 win_wp_reg    [NUM_WIN];
  logic [BANK_BITS-1:0] win_bank_reg  [NUM_WIN];
  logic [NUM_WIN-1:0]   en_reg;
  logic [NUM_WIN-1:0]   hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
      always_ff @(posedge Clk) begin
        if (Reset) begin
          win_isram_reg[gi] <= 1'b0;
          win_wp_reg[gi]    <= 1'b0;
          win_bank_reg[gi]  <= '0;
        end else if (bank_we && smp_off == 16'(gi)) begin
          win_isram_reg[gi] <= data_smp_reg[7];
          win_wp_reg[gi]    <= data_smp_reg[6];
          win_bank_reg[gi]  <= data_smp_reg[BANK_BITS-1:0];
        end
      end

      assign hit[gi] = en_reg[gi] & (Addr[15:12] == WIN_PAGES[4*gi +: 4]);
    end
  endgenerate

  // Control register. Lock set and unlock never coincide: they come from
  // writes to different addresses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      en_reg     <= '0;
      locked_reg <= 1'b0;
    end else if (ctrl_we) begin
      en_reg <= data_smp_reg[NUM_WIN-1:0];
      if (data_smp_reg[7]) locked_reg <= 1'b1;
    end else if (unlock) begin
      locked_reg <= 1'b0;
    end
  end

  // Key FSM: only committed writes into the register block move it.
  key_state_t key_reg, key_next;

  always_ff @(posedge Clk) begin
    if (Reset) key_reg <= K_IDLE;
    else       key_reg <= key_next;
  end

  always_comb begin
    key_next = key_reg;
    unlock   = 1'b0;
    if (commit_wr) begin
      case (key_reg)
        K_IDLE: if (key_we && data_smp_reg == 8'hA5) key_next = K_A5;
        K_A5: begin
          if (key_we && data_smp_reg == 8'hA5) begin
            key_next = K_A5;
          end else begin
            key_next = K_IDLE;
            if (key_we && data_smp_reg == 8'h5A) unlock = 1'b1;
          end
        end
        default: key_next = K_IDLE;
      endcase
    end
  end

  // Window decode: scan high to low so the lowest hitting index wins.
  always_comb begin
    logic sel_hit, sel_ram, sel_wp;
    sel_hit = 1'b0;
    sel_ram = 1'b0;
    sel_wp  = 1'b0;
    RA      = '0;
    NRAMCS  = 1'b1;
    NROMCS  = 1'b1;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit = 1'b1;
        sel_ram = win_isram_reg[i];
        sel_wp  = win_wp_reg[i];
        RA      = win_bank_reg[i];
      end
    end
    if (sel_hit) begin
      if (sel_ram) NRAMCS = sel_wp & ~RW;
      else         NROMCS = 1'b0;
    end
  end

  // Register readback
  logic [15:0] rd_off;
  assign rd_off = Addr - REG_BASE;
  assign DataOE = PHI2 & RW & (rd_off <= KEY_OFF);

  always_comb begin
    DataOut = 8'h00;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (rd_off == 16'(i))
        DataOut = {win_isram_reg[i], win_wp_reg[i], 6'(win_bank_reg[i])};
    end
    if (rd_off == CTRL_OFF) begin
      DataOut    = 8'(en_reg);
      DataOut[7] = locked_reg;  // with 8 windows bit 7 reads as the lock
    end
  end

  // Strobe FSM; strobes are registered from the next state so they are
  // glitch-free and released on the same Clk as the register commit.
  strobe_state_t st_reg, st_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic          rw_act_reg, rw_act_next;
  logic          nrds_reg, nwds_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_reg     <= S_IDLE;
      cnt_reg    <= 3'd0;
      rw_act_reg <= 1'b1;
      nrds_reg   <= 1'b1;
      nwds_reg   <= 1'b1;
    end else begin
      st_reg     <= st_next;
      cnt_reg    <= cnt_next;
      rw_act_reg <= rw_act_next;
      nrds_reg   <= ~((st_next == S_ACT) & rw_act_next);
      nwds_reg   <= ~((st_next == S_ACT) & ~rw_act_next);
    end
  end

  always_comb begin
    st_next     = st_reg;
    cnt_next    = cnt_reg;
    rw_act_next = rw_act_reg;
    case (st_reg)
      S_IDLE: begin
        if (phi_rise) begin
          st_next  = S_DLY;
          cnt_next = DLY_LOAD;
        end
      end
      S_DLY: begin
        if (phi_fall) begin
          st_next = S_IDLE;
        end else if (cnt_reg == 3'd0) begin
          st_next     = S_ACT;
          rw_act_next = RW;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_ACT: if (phi_fall) st_next = S_IDLE;
      default: st_next = S_IDLE;
    endcase
  end

  assign NRDS   = nrds_reg;
  assign NWDS   = nwds_reg;
  assign Locked = locked_reg;

endmodule

// File: tb/tb_atom_bank_mapper.sv
// Directed testbench for atom_bank_mapper. A second instance with windows 0
// and 1 both on page $6 exercises the duplicate-page priority rule.
module tb_atom_bank_mapper;

  logic        Clk = 1'b0;
  logic        Reset, PHI2, RW;
  logic [15:0] Addr;
  logic [7:0]  DataIn;

  logic [7:0] DataOut;
  logic       DataOE, NRAMCS, NROMCS, NRDS, NWDS, Locked;
  logic [4:0] RA;

  logic [7:0] d_DataOut;
  logic       d_DataOE, d_NRAMCS, d_NROMCS, d_NRDS, d_NWDS, d_Locked;
  logic [4:0] d_RA;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  atom_bank_mapper u_dut (
    .Clk(Clk), .Reset(Reset), .PHI2(PHI2), .Addr(Addr), .RW(RW), .DataIn(DataIn),
    .DataOut(DataOut), .DataOE(DataOE), .RA(RA), .NRAMCS(NRAMCS), .NROMCS(NROMCS),
    .NRDS(NRDS), .NWDS(NWDS), .Locked(Locked)
  );

  atom_bank_mapper #(.WIN_PAGES(32'h0000EA66)) u_dup (
    .Clk(Clk), .Reset(Reset), .PHI2(PHI2), .Addr(Addr), .RW(RW), .DataIn(DataIn),
    .DataOut(d_DataOut), .DataOE(d_DataOE), .RA(d_RA), .NRAMCS(d_NRAMCS), .NROMCS(d_NROMCS),
    .NRDS(d_NRDS), .NWDS(d_NWDS), .Locked(d_Locked)
  );

  // One full PHI2 cycle; captures mid-high-phase observations and whether
  // each strobe went low at any point in the cycle.
  task automatic do_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                          output logic [7:0] rd, output logic oe, output logic ramcs,
                          output logic romcs, output logic [4:0] ra,
                          output logic saw_rd, output logic saw_wr);
    saw_rd = 1'b0; saw_wr = 1'b0; rd = 8'h00; oe = 1'b0;
    ramcs = 1'b1; romcs = 1'b1; ra = 5'd0;
    @(negedge Clk);
    Addr = a; RW = rw; DataIn = d;
    repeat (2) @(negedge Clk);
    PHI2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (!NRDS) saw_rd = 1'b1;
      if (!NWDS) saw_wr = 1'b1;
      if (k == 8) begin
        rd = DataOut; oe = DataOE; ramcs = NRAMCS; romcs = NROMCS; ra = RA;
      end
    end
    PHI2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (!NRDS) saw_rd = 1'b1;
      if (!NWDS) saw_wr = 1'b1;
    end
    RW = 1'b1;
    $display("cycle addr=%h rw=%b din=%h dout=%h ramcs=%b romcs=%b ra=%h rd=%b wr=%b locked=%b",
             a, rw, d, rd, ramcs, romcs, ra, saw_rd, saw_wr, Locked);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] rd; logic oe, ramcs, romcs, srd, swr; logic [4:0] ra;
    do_cycle(a, 1'b0, d, rd, oe, ramcs, romcs, ra, srd, swr);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] rd, output logic oe);
    logic ramcs, romcs, srd, swr; logic [4:0] ra;
    do_cycle(a, 1'b1, 8'h00, rd, oe, ramcs, romcs, ra, srd, swr);
  endtask

  task automatic test_reset;
    logic [7:0] rd; logic oe;
    Reset = 1'b1; PHI2 = 1'b0; Addr = 16'h0000; RW = 1'b1; DataIn = 8'h00;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++; if (NRDS !== 1'b1) begin errors++; $display("FAIL reset_nrds got %b want 1", NRDS); end
    checks++; if (NWDS !== 1'b1) begin errors++; $display("FAIL reset_nwds got %b want 1", NWDS); end
    checks++; if (DataOE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", DataOE); end
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", Locked); end
    for (int i = 0; i < 6; i++) begin
      bus_rd(16'hBFE0 + 16'(i), rd, oe);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, rd); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL reset_oe%0d got %b want 1", i, oe); end
    end
    Addr = 16'hA123;
    @(negedge Clk);
    checks++; if (NRAMCS !== 1'b1 || NROMCS !== 1'b1 || RA !== 5'd0) begin
      errors++; $display("FAIL reset_decode got ram=%b rom=%b ra=%h want 1 1 00", NRAMCS, NROMCS, RA);
    end
  endtask

  task automatic test_map_read;
    logic [7:0] rd; logic oe;
    int first_low, first_high;
    bus_wr(16'hBFE2, 8'h85);
    bus_wr(16'hBFE4, 8'h04);
    bus_rd(16'hBFE2, rd, oe);
    checks++; if (rd !== 8'h85) begin errors++; $display("FAIL bank2_rb got %h want 85", rd); end
    bus_rd(16'hBFE4, rd, oe);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL ctrl_rb got %h want 04", rd); end
    // Strobe timing, counting Clk edges from the PHI2 edges
    @(negedge Clk);
    Addr = 16'hA000; RW = 1'b1;
    repeat (2) @(negedge Clk);
    PHI2 = 1'b1;
    first_low = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      if (!NRDS && first_low == 0) first_low = k;
    end
    checks++; if (first_low != 5) begin errors++; $display("FAIL nrds_assert got %0d want 5", first_low); end
    checks++; if (NRAMCS !== 1'b0 || NROMCS !== 1'b1 || RA !== 5'h05) begin
      errors++; $display("FAIL map_read got ram=%b rom=%b ra=%h want 0 1 05", NRAMCS, NROMCS, RA);
    end
    checks++; if (NWDS !== 1'b1) begin errors++; $display("FAIL map_read_nwds got %b want 1", NWDS); end
    @(negedge Clk);
    PHI2 = 1'b0;
    first_high = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      if (NRDS && first_high == 0) first_high = k;
    end
    checks++; if (first_high != 3) begin errors++; $display("FAIL nrds_release got %0d want 3", first_high); end
    $display("timing read A000 assert=%0d release=%0d", first_low, first_high);
  endtask

  task automatic test_wp;
    logic [7:0] rd; logic oe, ramcs, romcs, srd, swr; logic [4:0] ra;
    bus_wr(16'hBFE2, 8'hC3);
    do_cycle(16'hA010, 1'b0, 8'h55, rd, oe, ramcs, romcs, ra, srd, swr);
    checks++; if (ramcs !== 1'b1 || romcs !== 1'b1 || ra !== 5'h03) begin
      errors++; $display("FAIL wp_write got ram=%b rom=%b ra=%h want 1 1 03", ramcs, romcs, ra);
    end
    checks++; if (swr !== 1'b1 || srd !== 1'b0) begin
      errors++; $display("FAIL wp_write_strobes got wr=%b rd=%b want 1 0", swr, srd);
    end
    do_cycle(16'hA010, 1'b1, 8'h00, rd, oe, ramcs, romcs, ra, srd, swr);
    checks++; if (ramcs !== 1'b0 || srd !== 1'b1 || swr !== 1'b0) begin
      errors++; $display("FAIL wp_read got ram=%b rd=%b wr=%b want 0 1 0", ramcs, srd, swr);
    end
  endtask

  task automatic test_rom;
    logic [7:0] rd; logic oe, ramcs, romcs, srd, swr; logic [4:0] ra;
    bus_wr(16'hBFE3, 8'h07);
    bus_wr(16'hBFE4, 8'h0C);
    bus_rd(16'hBFE4, rd, oe);
    checks++; if (rd !== 8'h0C) begin errors++; $display("FAIL rom_ctrl_rb got %h want 0C", rd); end
    do_cycle(16'hE123, 1'b1, 8'h00, rd, oe, ramcs, romcs, ra, srd, swr);
    checks++; if (ramcs !== 1'b1 || romcs !== 1'b0 || ra !== 5'h07) begin
      errors++; $display("FAIL rom_read got ram=%b rom=%b ra=%h want 1 0 07", ramcs, romcs, ra);
    end
    do_cycle(16'hE123, 1'b0, 8'hAA, rd, oe, ramcs, romcs, ra, srd, swr);
    checks++; if (ramcs !== 1'b1 || romcs !== 1'b0) begin
      errors++; $display("FAIL rom_write got ram=%b rom=%b want 1 0", ramcs, romcs);
    end
  endtask

  task automatic test_lock;
    logic [7:0] rd; logic oe;
    bus_wr(16'hBFE4, 8'h84);
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL lock_set got %b want 1", Locked); end
    bus_wr(16'hBFE2, 8'h01);
    bus_rd(16'hBFE2, rd, oe);
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL lock_bank_ignored got %h want C3", rd); end
    bus_rd(16'hBFE4, rd, oe);
    checks++; if (rd !== 8'h84) begin errors++; $display("FAIL lock_ctrl_rb got %h want 84", rd); end
    bus_wr(16'hBFE5, 8'hA5);
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL lock_half_key got %b want 1", Locked); end
    bus_wr(16'hBFE5, 8'h5A);
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL unlock got %b want 0", Locked); end
    bus_rd(16'hBFE4, rd, oe);
    checks++; if (rd !== 8'h04) begin errors++; $display("FAIL unlock_ctrl_rb got %h want 04", rd); end
    bus_wr(16'hBFE4, 8'h84);
    bus_wr(16'hBFE5, 8'hA5);
    bus_wr(16'hBFE5, 8'hA5);
    bus_wr(16'hBFE5, 8'h5A);
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL unlock_a5a5 got %b want 0", Locked); end
    bus_wr(16'hBFE4, 8'h84);
    bus_wr(16'hBFE5, 8'hA5);
    bus_wr(16'hBFE0, 8'h12);
    bus_wr(16'hBFE5, 8'h5A);
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL key_broken got %b want 1", Locked); end
    bus_rd(16'hBFE0, rd, oe);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL key_broken_bank0 got %h want 00", rd); end
    bus_wr(16'hBFE5, 8'hA5);
    bus_wr(16'hBFE5, 8'h5A);
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL final_unlock got %b want 0", Locked); end
  endtask

  task automatic test_dup;
    bus_wr(16'hBFE0, 8'h81);
    bus_wr(16'hBFE1, 8'h82);
    bus_wr(16'hBFE4, 8'h03);
    @(negedge Clk);
    Addr = 16'h6000; RW = 1'b1;
    @(negedge Clk);
    checks++; if (RA !== 5'h01 || NRAMCS !== 1'b0) begin
      errors++; $display("FAIL main_6000 got ra=%h ram=%b want 01 0", RA, NRAMCS);
    end
    checks++; if (d_RA !== 5'h01 || d_NRAMCS !== 1'b0 || d_NROMCS !== 1'b1) begin
      errors++; $display("FAIL dup_6000 got ra=%h ram=%b rom=%b want 01 0 1", d_RA, d_NRAMCS, d_NROMCS);
    end
    Addr = 16'h7000;
    @(negedge Clk);
    checks++; if (RA !== 5'h02 || NRAMCS !== 1'b0) begin
      errors++; $display("FAIL main_7000 got ra=%h ram=%b want 02 0", RA, NRAMCS);
    end
    checks++; if (d_RA !== 5'h00 || d_NRAMCS !== 1'b1 || d_NROMCS !== 1'b1) begin
      errors++; $display("FAIL dup_7000 got ra=%h ram=%b rom=%b want 00 1 1", d_RA, d_NRAMCS, d_NROMCS);
    end
    $display("dup decode 6000/7000 main ra=%h dup ra=%h", RA, d_RA);
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; logic oe, ramcs, romcs, srd, swr; logic [4:0] ra;
    @(negedge Clk);
    Addr = 16'hBFE1; RW = 1'b0; DataIn = 8'h99;
    repeat (2) @(negedge Clk);
    PHI2 = 1'b1;
    repeat (7) @(negedge Clk);
    checks++; if (NWDS !== 1'b0) begin errors++; $display("FAIL mid_nwds_low got %b want 0", NWDS); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++; if (NWDS !== 1'b1) begin errors++; $display("FAIL mid_nwds_release got %b want 1", NWDS); end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    PHI2 = 1'b0;
    repeat (8) @(negedge Clk);
    RW = 1'b1;
    $display("reset mid-write to BFE1");
    bus_rd(16'hBFE1, rd, oe);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_no_commit got %h want 00", rd); end
    bus_rd(16'hBFE4, rd, oe);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_ctrl_reset got %h want 00", rd); end
    do_cycle(16'hBFE1, 1'b0, 8'h44, rd, oe, ramcs, romcs, ra, srd, swr);
    checks++; if (swr !== 1'b1) begin errors++; $display("FAIL resume_nwds got %b want 1", swr); end
    bus_rd(16'hBFE1, rd, oe);
    checks++; if (rd !== 8'h44) begin errors++; $display("FAIL resume_write got %h want 44", rd); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_map_read();
    test_wp();
    test_rom();
    test_lock();
    test_dup();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
